// File: rtl/pc_pkg.sv
// Shared next-PC mode encoding and default vectors for the PC/RAS unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    BR   = 3'd1,
    J    = 3'd2,
    JR   = 3'd3,
    CALL = 3'd4,
    RET  = 3'd5
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: pushing when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  push_ptr;

  assign push_ptr = top_ptr + PTR_W'(1);
  assign top      = mem[top_ptr];
  assign empty    = (count == CNT_W'(0));
  assign full     = (count == CNT_W'(DEPTH));

  // Pointer and occupancy update; a push at full leaves the count saturated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= push_ptr;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      count   <= count - CNT_W'(1);
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[push_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with branch/jump/call/return selection and a return-address stack.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        pc_sel,
  input  logic              br_taken,
  input  logic [31:0]       sign_imm,
  input  logic [25:0]       ins_addr,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              stall,
  input  logic              exc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] next_epc;
  logic              next_fault;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] br_target;

  assign pc_plus4  = pc + ADDR_W'(4);
  // Jump keeps the region bits above bit 27 of pc+4 (none when ADDR_W is 28).
  assign j_target  = (pc_plus4 & ~LOW_MASK) | ADDR_W'({ins_addr, 2'b00});
  assign br_target = pc_plus4 + ADDR_W'({sign_imm, 2'b00});

  ras_stack #(
    .DEPTH  (RAS_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Next-PC selection with priority exc > stall > pc_sel.
  always_comb begin
    next_pc    = pc_plus4;
    next_epc   = epc;
    next_fault = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (exc) begin
      next_pc  = EXC_PC;
      next_epc = pc;
    end else if (stall) begin
      next_pc = pc;
    end else begin
      case (pc_sel_e'(pc_sel))
        BR:   if (br_taken) next_pc = br_target;
        J:    next_pc = j_target;
        JR: begin
          if (reg_target[1:0] == 2'b00) begin
            next_pc = reg_target;
          end else begin
            next_pc    = EXC_PC;
            next_fault = 1'b1;
          end
        end
        CALL: begin
          next_pc  = j_target;
          ras_push = 1'b1;
        end
        RET: begin
          if (!ras_empty) begin
            next_pc = ras_top;
            ras_pop = 1'b1;
          end else begin
            next_fault = 1'b1;
          end
        end
        default: next_pc = pc_plus4;
      endcase
    end
  end

  // Architectural state; low two pc bits are forced to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RST_PC;
      epc   <= RST_PC;
      fault <= 1'b0;
    end else begin
      pc    <= {next_pc[ADDR_W-1:2], 2'b00};
      epc   <= next_epc;
      fault <= next_fault;
    end
  end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in bits; legal range 28..32.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_0080, PC value loaded on exception or misaligned target.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, 2..16.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 pc_sel  input  3  next-PC mode: SEQ, BR, J, JR, CALL, RET (encoded in package); other codes treated as SEQ.
REQ-008 br_taken  input  1  branch condition; used only when pc_sel=BR.
REQ-009 sign_imm  input  32  sign-extended word offset for BR.
REQ-010 ins_addr  input  26  jump index for J/CALL.
REQ-011 reg_target  input  ADDR_W  register target for JR.
REQ-012 stall  input  1  hold PC and RAS this cycle.
REQ-013 exc  input  1  exception request.
REQ-014 pc  output  ADDR_W  current instruction address, registered.
REQ-015 pc_plus4  output  ADDR_W  pc+4, combinational.
REQ-016 epc  output  ADDR_W  PC of the instruction at the last exception, registered.
REQ-017 ras_empty  output  1  RAS holds zero valid entries.
REQ-018 ras_full  output  1  RAS holds RAS_DEPTH valid entries.
REQ-019 fault  output  1  one-cycle registered pulse on RAS underflow or misaligned JR target.

Function
REQ-020 All PC arithmetic SHALL be modulo 2^ADDR_W; pc[1:0] SHALL always be 00.
REQ-021 Per-edge priority SHALL be: exc > stall > pc_sel action.
REQ-022 exc=1: pc<=EXC_VEC, epc<=pc, RAS unchanged, fault unchanged (0).
REQ-023 stall=1 (exc=0): pc, epc and RAS hold; fault<=0.
REQ-024 SEQ: pc<=pc+4.
REQ-025 BR: pc<=pc+4+(sign_imm<<2) truncated to ADDR_W if br_taken=1, else pc+4.
REQ-026 J: pc<={pc_plus4[ADDR_W-1:28], ins_addr, 2'b00}; for ADDR_W=28 pc<={ins_addr,2'b00}.
REQ-027 CALL: pc<=J target, and pc+4 pushed onto RAS in the same edge.
REQ-028 JR: pc<=reg_target if reg_target[1:0]==00, else pc<=EXC_VEC and fault<=1.
REQ-029 RET, RAS non-empty: pc<=top of RAS, pop.
REQ-030 RET, RAS empty: pc<=pc+4, no pop, fault<=1.
REQ-031 Push when full SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH, ras_full stays 1.
REQ-032 RAS SHALL be a circular buffer with a top pointer and a count register of width clog2(RAS_DEPTH)+1.
REQ-033 fault SHALL be 0 in every cycle not named in REQ-028/030.

Reset
REQ-034 reset low SHALL immediately set pc=RESET_VEC, epc=RESET_VEC, RAS count=0, top pointer=0, fault=0, independent of clk.
REQ-035 RAS entry storage SHALL NOT require reset; reset asserted mid-CALL/RET SHALL discard that operation.
REQ-036 The first rising edge after reset deasserts SHALL apply normal next-PC selection from RESET_VEC.

Structure
REQ-037 Package pc_pkg SHALL hold the pc_sel enum (SEQ=0, BR=1, J=2, JR=3, CALL=4, RET=5) and the default vector constants.
REQ-038 The RAS SHALL be a separate sub-module ras_stack (push, pop, top, empty, full), parametrised by RAS_DEPTH and ADDR_W.
REQ-039 Target selection SHALL be combinational; only pc, epc, fault and RAS state are registered.

Verification
REQ-040 Reset released, SEQ for 3 cycles -> pc 0,4,8,C.
REQ-041 pc=0x100, BR, br_taken=1, sign_imm=0xFFFF_FFFE -> pc=0x0FC; br_taken=0 -> pc=0x104.
REQ-042 pc=0x1000_0010, CALL ins_addr=0x000_0040 -> pc=0x1000_0100, ras_empty=0; then RET -> pc=0x1000_0014, ras_empty=1.
REQ-043 RAS_DEPTH=4: 5 nested CALLs then 5 RETs -> first 4 RETs return the 4 newest link addresses, 5th RET gives pc+4 and fault=1.
REQ-044 JR reg_target=0x202 -> pc=EXC_VEC, fault=1; exc=1 with stall=1 at pc=0x40 -> pc=EXC_VEC, epc=0x40.
REQ-045 reset asserted mid-cycle between edges -> pc=RESET_VEC before next edge, ras_empty=1.
